tx_code_sequencer: RTL and testbench

Transmit-side controller that accepts 2-bit symbols from upstream logic, queues them, expands each into its 8-bit mark/space code, and serialises that code MSB-first onto the line at a programmable bit rate with an inter-symbol gap. It also drives the 8-bit code bus that feeds the transmitter's 7-segment decoder, so the symbol currently on air is shown on HEX0. It sits between the user/control logic and the TX line driver.

---
 rtl/tx_pkg.sv | 30 +++
 rtl/tx_sym_fifo.sv | 57 +++++
 rtl/tx_code_sequencer.sv | 141 ++++++++++++++
 tb/tb_tx_code_sequencer.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tx_pkg.sv
// Shared definitions for the transmit code sequencer and the HEX display decoder:
// FSM states, symbol mark/space codes and the symbol-to-code mapping.
package tx_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2,
        GAP  = 2'd3
    } tx_state_t;

    localparam logic [7:0] CODE_SYM0  = 8'b1000_0000;
    localparam logic [7:0] CODE_SYM1  = 8'b1010_0000;
    localparam logic [7:0] CODE_SYM2  = 8'b1010_1000;
    localparam logic [7:0] CODE_SYM3  = 8'b1010_1010;
    localparam logic [7:0] CODE_BLANK = 8'h00;

    function automatic logic [7:0] sym_to_code(input logic [1:0] sym);
        logic [7:0] code_v;
        case (sym)
            2'd0:    code_v = CODE_SYM0;
            2'd1:    code_v = CODE_SYM1;
            2'd2:    code_v = CODE_SYM2;
            2'd3:    code_v = CODE_SYM3;
            default: code_v = CODE_BLANK;
        endcase
        return code_v;
    endfunction

endpackage

// File: rtl/tx_sym_fifo.sv
// Synchronous symbol queue with first-word fall-through read data.
// Writes to a full queue are dropped even when a read happens in the same cycle.
module tx_sym_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_wr_en,
    input  logic [1:0] i_wr_data,
    input  logic       i_rd_en,
    output logic [1:0] o_rd_data,
    output logic       o_full,
    output logic       o_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [1:0]       r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == {CNT_W{1'b0}});
    assign o_rd_data = r_mem[r_rd_ptr];
    assign w_push    = i_wr_en && !o_full;
    assign w_pop     = i_rd_en && !o_empty;

    // Storage, pointers and occupancy count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= 2'd0;
            end
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_count  <= {CNT_W{1'b0}};
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_wr_data;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/tx_code_sequencer.sv
// Queues 2-bit symbols, expands each to its 8-bit mark/space code and shifts it out
// MSB-first at CLK_DIV cycles per bit, followed by a GAP_BITS-long silent gap.
module tx_code_sequencer
    import tx_pkg::*;
#(
    parameter int CLK_DIV    = 25000,
    parameter int GAP_BITS   = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sym_valid,
    input  logic [1:0] sym_data,
    output logic       sym_ready,
    output logic       tx_bit,
    output logic       tx_active,
    output logic [7:0] code,
    output logic       done
);

    localparam int GAP_CYC = GAP_BITS * CLK_DIV;
    localparam int DIV_W   = $clog2(CLK_DIV);
    localparam int GAP_W   = $clog2(GAP_CYC);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);

    tx_state_t        r_state, w_next_state;
    logic [DIV_W-1:0] r_div, w_next_div;
    logic [2:0]       r_bit_cnt, w_next_bit_cnt;
    logic [GAP_W-1:0] r_gap_cnt, w_next_gap_cnt;
    logic [7:0]       r_shift, w_next_shift;
    logic [7:0]       r_code, w_next_code;
    logic             r_tx_bit, r_tx_active, r_done;
    logic             w_pop, w_full, w_empty;
    logic [1:0]       w_fifo_data;

    tx_sym_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (sym_valid),
        .i_wr_data (sym_data),
        .i_rd_en   (w_pop),
        .o_rd_data (w_fifo_data),
        .o_full    (w_full),
        .o_empty   (w_empty)
    );

    assign sym_ready = !w_full;
    assign tx_bit    = r_tx_bit;
    assign tx_active = r_tx_active;
    assign code      = r_code;
    assign done      = r_done;

    // Next-state, counter and shift-register logic.
    always_comb begin
        w_next_state   = r_state;
        w_next_div     = r_div;
        w_next_bit_cnt = r_bit_cnt;
        w_next_gap_cnt = r_gap_cnt;
        w_next_shift   = r_shift;
        w_next_code    = r_code;
        w_pop          = 1'b0;
        case (r_state)
            IDLE: begin
                w_next_code = CODE_BLANK;
                if (!w_empty) begin
                    w_next_state = LOAD;
                end else begin
                    w_next_state = IDLE;
                end
            end
            LOAD: begin
                w_pop          = 1'b1;
                w_next_shift   = sym_to_code(w_fifo_data);
                w_next_code    = sym_to_code(w_fifo_data);
                w_next_div     = {DIV_W{1'b0}};
                w_next_bit_cnt = 3'd0;
                w_next_gap_cnt = {GAP_W{1'b0}};
                w_next_state   = SEND;
            end
            SEND: begin
                if (r_div == DIV_LAST) begin
                    w_next_div     = {DIV_W{1'b0}};
                    w_next_shift   = {r_shift[6:0], 1'b0};
                    w_next_bit_cnt = r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) begin
                        w_next_state   = GAP;
                        w_next_gap_cnt = {GAP_W{1'b0}};
                    end else begin
                        w_next_state = SEND;
                    end
                end else begin
                    w_next_div = r_div + DIV_W'(1);
                end
            end
            GAP: begin
                if (r_gap_cnt == GAP_LAST) begin
                    if (!w_empty) begin
                        w_next_state = LOAD;
                    end else begin
                        w_next_state = IDLE;
                        w_next_code  = CODE_BLANK;
                    end
                end else begin
                    w_next_gap_cnt = r_gap_cnt + GAP_W'(1);
                end
            end
            default: begin
                w_next_state = IDLE;
                w_next_code  = CODE_BLANK;
            end
        endcase
    end

    // State and counters; outputs are registered from the next-state values so they
    // line up with the state they describe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_div       <= {DIV_W{1'b0}};
            r_bit_cnt   <= 3'd0;
            r_gap_cnt   <= {GAP_W{1'b0}};
            r_shift     <= 8'h00;
            r_code      <= CODE_BLANK;
            r_tx_bit    <= 1'b0;
            r_tx_active <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_div       <= w_next_div;
            r_bit_cnt   <= w_next_bit_cnt;
            r_gap_cnt   <= w_next_gap_cnt;
            r_shift     <= w_next_shift;
            r_code      <= w_next_code;
            r_tx_bit    <= (w_next_state == SEND) && w_next_shift[7];
            r_tx_active <= (w_next_state != IDLE);
            r_done      <= (w_next_state == GAP) && (w_next_gap_cnt == GAP_LAST);
        end
    end

endmodule

// File: tb/tb_tx_code_sequencer.sv
// Directed bench for tx_code_sequencer with CLK_DIV=4, GAP_BITS=3, FIFO_DEPTH=4.
module tb_tx_code_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       sym_valid;
    logic [1:0] sym_data;
    logic       sym_ready;
    logic       tx_bit;
    logic       tx_active;
    logic [7:0] code;
    logic       done;

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] done_codes[$];

    typedef struct {
        logic [1:0] sym;
        logic [7:0] exp_code;
    } vec_t;

    vec_t vecs[4];

    tx_code_sequencer #(.CLK_DIV(4), .GAP_BITS(3), .FIFO_DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .sym_valid (sym_valid),
        .sym_data  (sym_data),
        .sym_ready (sym_ready),
        .tx_bit    (tx_bit),
        .tx_active (tx_active),
        .code      (code),
        .done      (done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst && done) done_codes.push_back(code);
    end

    task automatic chk1(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [1:0] s);
        sym_data  = s;
        sym_valid = 1'b1;
        tick();
        sym_valid = 1'b0;
    endtask

    // One symbol from idle: checks latency, every serial cycle and the done position.
    task automatic run_single(input int idx, input logic [1:0] s, input logic [7:0] c);
        logic eb;
        push_one(s);
        chk1($sformatf("s%0d_active_E0", idx), tx_active, 1'b0);
        tick();
        chk1($sformatf("s%0d_active_E1", idx), tx_active, 1'b1);
        chk8($sformatf("s%0d_code_E1", idx), code, 8'h00);
        tick();
        chk8($sformatf("s%0d_code_E2", idx), code, c);
        for (int k = 0; k < 44; k++) begin
            eb = (k < 32) ? c[7 - k / 4] : 1'b0;
            chk1($sformatf("s%0d_bit_k%0d", idx, k), tx_bit, eb);
            chk1($sformatf("s%0d_done_k%0d", idx, k), done, (k == 43));
            tick();
        end
        chk8($sformatf("s%0d_code_idle", idx), code, 8'h00);
        chk1($sformatf("s%0d_active_idle", idx), tx_active, 1'b0);
    endtask

    task automatic check_codes(input string tag, input logic [7:0] exp[], input int n);
        logic [7:0] got;
        chki({tag, "_count"}, done_codes.size(), n);
        for (int i = 0; i < n; i++) begin
            got = (i < done_codes.size()) ? done_codes[i] : 8'hFF;
            chk8($sformatf("%s_code%0d", tag, i), got, exp[i]);
        end
    endtask

    initial begin
        logic [7:0] exp_codes[];
        logic [1:0] fsyms[6];
        int t;
        int n;
        int stall;
        int activity;
        logic saw_done;
        logic load_ok;

        vecs[0] = '{sym: 2'd2, exp_code: 8'hA8};
        vecs[1] = '{sym: 2'd0, exp_code: 8'h80};
        vecs[2] = '{sym: 2'd1, exp_code: 8'hA0};
        vecs[3] = '{sym: 2'd3, exp_code: 8'hAA};

        // Reset
        rst = 1'b1; sym_valid = 1'b0; sym_data = 2'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        tick();
        chk1("rst_tx_bit", tx_bit, 1'b0);
        chk8("rst_code", code, 8'h00);
        chk1("rst_active", tx_active, 1'b0);
        chk1("rst_ready", sym_ready, 1'b1);
        chk1("rst_done", done, 1'b0);

        // Single symbols from idle, table-driven
        done_codes.delete();
        for (int i = 0; i < 4; i++) begin
            run_single(i, vecs[i].sym, vecs[i].exp_code);
        end
        exp_codes = new[4];
        exp_codes[0] = 8'hA8; exp_codes[1] = 8'h80; exp_codes[2] = 8'hA0; exp_codes[3] = 8'hAA;
        check_codes("single", exp_codes, 4);

        // Idle valid pulses for symbols 0..3 in order
        done_codes.delete();
        for (int i = 0; i < 4; i++) begin
            chk1($sformatf("pulse_ready%0d", i), sym_ready, 1'b1);
            push_one(2'(i));
            t = 0;
            while (tx_active !== 1'b0 || t < 2) begin
                if (t > 200) break;
                tick();
                t++;
            end
        end
        exp_codes[0] = 8'h80; exp_codes[1] = 8'hA0; exp_codes[2] = 8'hA8; exp_codes[3] = 8'hAA;
        check_codes("pulse", exp_codes, 4);

        // Back-to-back 0 then 3
        done_codes.delete();
        sym_data = 2'd0; sym_valid = 1'b1;
        tick();
        sym_data = 2'd3;
        tick();
        sym_valid = 1'b0;
        t = 0;
        while (tx_bit !== 1'b1 && t < 10) begin tick(); t++; end
        chk1("b2b_first_lead", tx_bit, 1'b1);
        chk8("b2b_first_code", code, 8'h80);
        n = 0; saw_done = 1'b0; load_ok = 1'b0;
        do begin
            tick();
            n++;
            if (n == 43) saw_done = done;
            if (n == 44) load_ok = tx_active && !tx_bit && !done && (code == 8'h80);
        end while (!(code == 8'hAA && tx_bit == 1'b1) && n < 200);
        chki("b2b_spacing", n, 45);
        chk1("b2b_done_before_load", saw_done, 1'b1);
        chk1("b2b_load_cycle", load_ok, 1'b1);
        t = 0;
        while (tx_active !== 1'b0 && t < 100) begin tick(); t++; end
        chk1("b2b_idle", tx_active, 1'b0);
        exp_codes = new[2];
        exp_codes[0] = 8'h80; exp_codes[1] = 8'hAA;
        check_codes("b2b", exp_codes, 2);

        // Full queue with sym_valid held high
        done_codes.delete();
        fsyms = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2};
        sym_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            sym_data = fsyms[i];
            chk1($sformatf("full_ready%0d", i), sym_ready, 1'b1);
            tick();
        end
        chk1("full_ready_low", sym_ready, 1'b0);
        sym_data = fsyms[5];
        stall = 0;
        while (sym_ready !== 1'b1 && stall < 200) begin tick(); stall++; end
        chki("full_stall", stall, 43);
        tick();
        sym_valid = 1'b0;
        t = 0;
        while (done_codes.size() < 6 && t < 2000) begin tick(); t++; end
        exp_codes = new[6];
        exp_codes[0] = 8'hA0; exp_codes[1] = 8'hA8; exp_codes[2] = 8'hAA;
        exp_codes[3] = 8'h80; exp_codes[4] = 8'hA0; exp_codes[5] = 8'hA8;
        check_codes("full", exp_codes, 6);
        repeat (3) tick();

        // Reset during bit 3 of symbol 1 with two symbols queued
        done_codes.delete();
        sym_valid = 1'b1;
        sym_data = 2'd1; tick();
        sym_data = 2'd2; tick();
        sym_data = 2'd3; tick();
        sym_valid = 1'b0;
        repeat (13) tick();
        chk1("mid_active_before", tx_active, 1'b1);
        chk8("mid_code_before", code, 8'hA0);
        #3 rst = 1'b1;
        #1;
        chk1("mid_rst_active", tx_active, 1'b0);
        chk8("mid_rst_code", code, 8'h00);
        chk1("mid_rst_bit", tx_bit, 1'b0);
        chk1("mid_rst_ready", sym_ready, 1'b1);
        chk1("mid_rst_done", done, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        activity = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (tx_bit !== 1'b0 || tx_active !== 1'b0 || done !== 1'b0) activity++;
        end
        chki("mid_post_activity", activity, 0);
        chki("mid_post_dones", done_codes.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
